// File: rtl/ulpi_link_sched.sv
//==============================================================================
// Module   : ulpi_link_sched
// Brief    : ULPI link-side bus scheduler: register access, TX packet path,
//            turnaround/abort handling and RX CMD extraction.
//            Define ULPI_EXT_REG_EN to build extended register access.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ulpi_link_sched #(
  parameter int MAX_RETRY = 3
) (
  input  logic       ulpi_clk,
  input  logic       ulpi_rst_n,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic       reg_err,
  output logic [7:0] reg_rdata,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd
);

  localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CMD      = 4'd1,
    EXT_ADDR = 4'd2,
    WDATA    = 4'd3,
    STP      = 4'd4,
    RD_TURN  = 4'd5,
    RD_DATA  = 4'd6,
    TX_PID   = 4'd7,
    TX_DATA  = 4'd8,
    TX_STP   = 4'd9,
    BACKOFF  = 4'd10
  } state_t;

  state_t               r_state, w_next;
  logic [7:0]           r_cmd, r_wdata, r_rdata, r_rxcmd;
  logic                 r_we, r_reg_ack, r_reg_err, r_pri_tx, r_bo_idle;
  logic                 r_dir_q, r_rxcmd_valid;
  logic [c_RETRY_W-1:0] r_retry;
  logic                 w_ext, w_reg_pend, w_accept, w_rx;
  logic                 w_grant_reg, w_grant_tx, w_done, w_fail, w_abort, w_capture;
  logic [7:0]           w_cmd;
`ifdef ULPI_EXT_REG_EN
  logic [7:0]           r_addr;
  logic                 r_ext;
`endif

  assign w_ext      = (reg_addr[7:6] != 2'b00) || (reg_addr[5:0] == 6'h2F);
  assign w_reg_pend = reg_req & ~r_reg_ack;   // requester still holds req during its ack
  assign w_accept   = ulpi_nxt & ~ulpi_dir;
  assign w_rx       = ulpi_dir & ~ulpi_nxt & r_dir_q & (r_state != RD_DATA);
`ifdef ULPI_EXT_REG_EN
  assign w_cmd = w_ext ? (reg_we ? 8'hAF : 8'hEF) : {1'b1, ~reg_we, reg_addr[5:0]};
`else
  assign w_cmd = {1'b1, ~reg_we, reg_addr[5:0]};
`endif

  assign reg_ack     = r_reg_ack;
  assign reg_err     = r_reg_err;
  assign reg_rdata   = r_rdata;
  assign rxcmd_valid = r_rxcmd_valid;
  assign rxcmd       = r_rxcmd;

  always_comb begin
    w_next        = r_state;
    w_grant_reg   = 1'b0;
    w_grant_tx    = 1'b0;
    w_done        = 1'b0;
    w_fail        = 1'b0;
    w_abort       = 1'b0;
    w_capture     = 1'b0;
    ulpi_stp      = 1'b0;
    ulpi_data_out = 8'h00;
    tx_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!ulpi_dir) begin
          if (w_reg_pend && (!tx_valid || !r_pri_tx)) w_grant_reg = 1'b1;
          else if (tx_valid)                          w_grant_tx  = 1'b1;
        end
        if (w_grant_tx) w_next = TX_PID;
        if (w_grant_reg) begin
`ifdef ULPI_EXT_REG_EN
          w_next = CMD;
`else
          if (w_ext) w_fail = 1'b1;
          else       w_next = CMD;
`endif
        end
      end
      CMD: begin
        ulpi_data_out = r_cmd;
        if (ulpi_dir) w_abort = 1'b1;
`ifdef ULPI_EXT_REG_EN
        else if (ulpi_nxt) w_next = r_ext ? EXT_ADDR : (r_we ? WDATA : RD_TURN);
      end
      EXT_ADDR: begin
        ulpi_data_out = r_addr;
        if (ulpi_dir) w_abort = 1'b1;
        else if (ulpi_nxt) w_next = r_we ? WDATA : RD_TURN;
`else
        else if (ulpi_nxt) w_next = r_we ? WDATA : RD_TURN;
`endif
      end
      WDATA: begin
        ulpi_data_out = r_wdata;
        if (ulpi_dir) w_abort = 1'b1;
        else if (ulpi_nxt) begin
          w_done = 1'b1;
          w_next = STP;
        end
      end
      STP: begin
        ulpi_stp = 1'b1;
        w_next   = IDLE;
      end
      // PHY flagging receive (nxt) instead of a plain turnaround, or
      // dropping dir before the data cycle, means the read was aborted.
      RD_TURN: begin
        if (ulpi_dir && ulpi_nxt) w_abort = 1'b1;
        else                      w_next  = RD_DATA;
      end
      RD_DATA: begin
        if (!ulpi_dir || ulpi_nxt) w_abort = 1'b1;
        else begin
          w_capture = 1'b1;
          w_done    = 1'b1;
          w_next    = IDLE;
        end
      end
      TX_PID, TX_DATA: begin
        tx_ready = w_accept;
        if (tx_valid)
          ulpi_data_out = (r_state == TX_PID) ? {4'b0100, tx_data[3:0]} : tx_data;
        if (ulpi_dir) w_next = IDLE;
        else if (w_accept && tx_valid) w_next = tx_last ? TX_STP : TX_DATA;
      end
      TX_STP: begin
        ulpi_stp = 1'b1;
        w_next   = IDLE;
      end
      BACKOFF: begin
        if (!ulpi_dir && r_bo_idle) w_next = CMD;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) begin
      if (r_retry >= c_RETRY_W'(MAX_RETRY - 1)) begin
        w_fail = 1'b1;
        w_next = IDLE;
      end else begin
        w_next = BACKOFF;
      end
    end
  end

  always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
    if (!ulpi_rst_n) begin
      r_state       <= IDLE;
      r_cmd         <= 8'h00;
      r_wdata       <= 8'h00;
      r_rdata       <= 8'h00;
      r_rxcmd       <= 8'h00;
      r_we          <= 1'b0;
      r_reg_ack     <= 1'b0;
      r_reg_err     <= 1'b0;
      r_pri_tx      <= 1'b0;
      r_bo_idle     <= 1'b0;
      r_dir_q       <= 1'b0;
      r_rxcmd_valid <= 1'b0;
      r_retry       <= '0;
`ifdef ULPI_EXT_REG_EN
      r_addr        <= 8'h00;
      r_ext         <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_reg_ack <= w_done | w_fail;
      r_reg_err <= w_fail;
      r_bo_idle <= (r_state == BACKOFF) & ~ulpi_dir;
      if (w_capture) r_rdata <= ulpi_data_in;
      if (w_done || w_fail) r_retry <= '0;
      else if (w_abort)     r_retry <= r_retry + c_RETRY_W'(1);
      if (w_grant_reg) begin
        r_cmd   <= w_cmd;
        r_we    <= reg_we;
        r_wdata <= reg_wdata;
`ifdef ULPI_EXT_REG_EN
        r_addr  <= reg_addr;
        r_ext   <= w_ext;
`endif
      end
      // Priority only flips when both sides contended; the winner yields next time.
      if (w_grant_reg && tx_valid)      r_pri_tx <= 1'b1;
      else if (w_grant_tx && w_reg_pend) r_pri_tx <= 1'b0;
      r_dir_q       <= ulpi_dir;
      r_rxcmd_valid <= w_rx;
      if (w_rx) r_rxcmd <= ulpi_data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ulpi_link_sched.sv
//==============================================================================
// Module   : tb_ulpi_link_sched
// Brief    : Directed self-checking bench for ulpi_link_sched.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ulpi_link_sched;

  localparam int MAX_RETRY = 3;

  logic       ulpi_clk = 1'b0;
  logic       ulpi_rst_n, ulpi_dir, ulpi_nxt, ulpi_stp;
  logic [7:0] ulpi_data_in, ulpi_data_out;
  logic       reg_req, reg_we, reg_ack, reg_err;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       tx_valid, tx_last, tx_ready, rxcmd_valid;
  logic [7:0] tx_data, rxcmd;
  int         n_run  = 0;
  int         n_fail = 0;

  ulpi_link_sched #(.MAX_RETRY(MAX_RETRY)) dut (
    .ulpi_clk(ulpi_clk), .ulpi_rst_n(ulpi_rst_n), .ulpi_dir(ulpi_dir),
    .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack),
    .reg_err(reg_err), .reg_rdata(reg_rdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .rxcmd_valid(rxcmd_valid), .rxcmd(rxcmd)
  );

  always #5 ulpi_clk = ~ulpi_clk;

  task automatic tick();
    @(posedge ulpi_clk);
    #1;
  endtask

  task automatic test_reset();
    ulpi_rst_n = 1'b0; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = 8'h00; reg_wdata = 8'h00;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    #3;
    n_run++; if ({ulpi_stp, reg_ack, reg_err, tx_ready, rxcmd_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {ulpi_stp, reg_ack, reg_err, tx_ready, rxcmd_valid}); end
    n_run++; if ({ulpi_data_out, reg_rdata, rxcmd} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", {ulpi_data_out, reg_rdata, rxcmd}); end
    repeat (2) tick();
    ulpi_rst_n = 1'b1;
    ulpi_dir = 1'b1; reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_wdata = 8'h45;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_run++; if ({ulpi_data_out, reg_ack} !== 9'h0) begin n_fail++; $display("FAIL dir_hold_idle: got %h want 000", {ulpi_data_out, reg_ack}); end
    end
    reg_req = 1'b0;
    tick();
    ulpi_dir = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_wdata = 8'h45; ulpi_nxt = 1'b1;
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h84) begin n_fail++; $display("FAIL areset_cmd: got %h want 84", ulpi_data_out); end
    #2 ulpi_rst_n = 1'b0;
    #1;
    n_run++; if (ulpi_data_out !== 8'h00) begin n_fail++; $display("FAIL areset_data: got %h want 00", ulpi_data_out); end
    reg_req = 1'b0;
    repeat (2) tick();
    ulpi_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arbitration();
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_wdata = 8'h45;
    tx_valid = 1'b1; tx_data = 8'hC3; tx_last = 1'b0; ulpi_nxt = 1'b1; ulpi_dir = 1'b0;
    #1;
    n_run++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL arb_idle_ready: got %b want 0", tx_ready); end
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h84) begin n_fail++; $display("FAIL arb_reg_first: got %h want 84", ulpi_data_out); end
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h45) begin n_fail++; $display("FAIL arb_wdata: got %h want 45", ulpi_data_out); end
    tick(); #1;
    n_run++; if ({ulpi_stp, reg_ack, reg_err} !== 3'b110) begin n_fail++; $display("FAIL arb_reg_ack: got %b want 110", {ulpi_stp, reg_ack, reg_err}); end
    reg_req = 1'b0;
    tick(); #1;
    n_run++; if ({ulpi_data_out, tx_ready} !== 9'h0) begin n_fail++; $display("FAIL arb_tx_grant: got %h want 000", {ulpi_data_out, tx_ready}); end
    tick(); #1;
    n_run++; if ({ulpi_data_out, tx_ready} !== {8'h43, 1'b1}) begin n_fail++; $display("FAIL tx_pid: got %h want 087", {ulpi_data_out, tx_ready}); end
    tick();
    tx_valid = 1'b0; #1;
    n_run++; if ({ulpi_stp, ulpi_data_out} !== 9'h0) begin n_fail++; $display("FAIL tx_gap: got %h want 000", {ulpi_stp, ulpi_data_out}); end
    tick();
    tx_valid = 1'b1; tx_data = 8'h11; #1;
    n_run++; if (ulpi_data_out !== 8'h11) begin n_fail++; $display("FAIL tx_byte2: got %h want 11", ulpi_data_out); end
    tick();
    tx_data = 8'h22; tx_last = 1'b1; #1;
    n_run++; if ({ulpi_data_out, tx_ready} !== {8'h22, 1'b1}) begin n_fail++; $display("FAIL tx_byte3: got %h want 045", {ulpi_data_out, tx_ready}); end
    tick();
    tx_valid = 1'b0; tx_last = 1'b0; #1;
    n_run++; if ({ulpi_stp, ulpi_data_out, tx_ready} !== {1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL tx_stp: got %h want 200", {ulpi_stp, ulpi_data_out, tx_ready}); end
    tick(); #1;
    n_run++; if (ulpi_stp !== 1'b0) begin n_fail++; $display("FAIL tx_stp_len: got %b want 0", ulpi_stp); end
    // Second contended pair: TX should now win.
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h05; reg_wdata = 8'h66;
    tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h45) begin n_fail++; $display("FAIL arb_tx_first: got %h want 45", ulpi_data_out); end
    tick();
    tx_valid = 1'b0; tx_last = 1'b0; #1;
    n_run++; if (ulpi_stp !== 1'b1) begin n_fail++; $display("FAIL arb2_tx_stp: got %b want 1", ulpi_stp); end
    tick(); tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h85) begin n_fail++; $display("FAIL arb2_reg_cmd: got %h want 85", ulpi_data_out); end
    tick(); tick(); #1;
    n_run++; if (reg_ack !== 1'b1) begin n_fail++; $display("FAIL arb2_reg_ack: got %b want 1", reg_ack); end
    reg_req = 1'b0;
    tick();
  endtask

  task automatic test_imm_write();
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_wdata = 8'h45; ulpi_nxt = 1'b1;
    #1;
    n_run++; if (ulpi_data_out !== 8'h00) begin n_fail++; $display("FAIL wr_idle: got %h want 00", ulpi_data_out); end
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h84) begin n_fail++; $display("FAIL wr_cmd: got %h want 84", ulpi_data_out); end
    tick(); #1;
    n_run++; if ({ulpi_data_out, reg_ack} !== {8'h45, 1'b0}) begin n_fail++; $display("FAIL wr_data: got %h want 08a", {ulpi_data_out, reg_ack}); end
    tick(); #1;
    n_run++; if ({ulpi_stp, ulpi_data_out, reg_ack, reg_err} !== {1'b1, 8'h00, 2'b10}) begin n_fail++; $display("FAIL wr_stp_ack: got %h want 402", {ulpi_stp, ulpi_data_out, reg_ack, reg_err}); end
    reg_req = 1'b0;
    tick(); #1;
    n_run++; if ({ulpi_stp, reg_ack} !== 2'b00) begin n_fail++; $display("FAIL wr_ack_len: got %b want 00", {ulpi_stp, reg_ack}); end
  endtask

  task automatic test_rxcmd();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; ulpi_data_in = 8'hFF;
    tick();
    ulpi_data_in = 8'h1D; #1;
    n_run++; if (rxcmd_valid !== 1'b0) begin n_fail++; $display("FAIL rx_turn: got %b want 0", rxcmd_valid); end
    tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; #1;
    n_run++; if ({rxcmd_valid, rxcmd} !== {1'b1, 8'h1D}) begin n_fail++; $display("FAIL rx_cmd: got %h want 11d", {rxcmd_valid, rxcmd}); end
    tick(); #1;
    n_run++; if ({rxcmd_valid, rxcmd} !== {1'b0, 8'h1D}) begin n_fail++; $display("FAIL rx_hold: got %h want 01d", {rxcmd_valid, rxcmd}); end
  endtask

  task automatic test_imm_read();
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 8'h16; ulpi_nxt = 1'b1; ulpi_dir = 1'b0;
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'hD6) begin n_fail++; $display("FAIL rd_cmd: got %h want d6", ulpi_data_out); end
    tick();
    ulpi_dir = 1'b1; ulpi_nxt = 1'b0; ulpi_data_in = 8'hEE;
    tick();
    ulpi_data_in = 8'hA7; #1;
    n_run++; if (rxcmd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_turn_rx: got %b want 0", rxcmd_valid); end
    tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; #1;
    n_run++; if ({reg_ack, reg_err, reg_rdata} !== {2'b10, 8'hA7}) begin n_fail++; $display("FAIL rd_ack: got %h want 2a7", {reg_ack, reg_err, reg_rdata}); end
    n_run++; if ({rxcmd_valid, rxcmd} !== {1'b0, 8'h1D}) begin n_fail++; $display("FAIL rd_data_rx: got %h want 01d", {rxcmd_valid, rxcmd}); end
    reg_req = 1'b0;
    tick(); #1;
    n_run++; if ({reg_ack, reg_rdata} !== {1'b0, 8'hA7}) begin n_fail++; $display("FAIL rd_hold: got %h want 0a7", {reg_ack, reg_rdata}); end
  endtask

  task automatic test_retry(input int n_aborts);
    bit done;
    done = 1'b0;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b1;
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h0A; reg_wdata = 8'h33;
    tick();
    for (int a = 0; a < MAX_RETRY && !done; a++) begin
      #1;
      n_run++; if (ulpi_data_out !== 8'h8A) begin n_fail++; $display("FAIL retry_cmd %0d: got %h want 8a", a, ulpi_data_out); end
      tick(); #1;
      n_run++; if (ulpi_data_out !== 8'h33) begin n_fail++; $display("FAIL retry_wdata %0d: got %h want 33", a, ulpi_data_out); end
      if (a < n_aborts) begin
        ulpi_dir = 1'b1;
        tick(); #1;
        if (a == MAX_RETRY - 1) begin
          n_run++; if ({reg_ack, reg_err} !== 2'b11) begin n_fail++; $display("FAIL retry_exhaust: got %b want 11", {reg_ack, reg_err}); end
          reg_req = 1'b0; ulpi_dir = 1'b0;
          tick(); #1;
          n_run++; if (reg_ack !== 1'b0) begin n_fail++; $display("FAIL retry_exhaust_len: got %b want 0", reg_ack); end
          done = 1'b1;
        end else begin
          n_run++; if ({reg_ack, ulpi_data_out} !== 9'h0) begin n_fail++; $display("FAIL retry_backoff %0d: got %h want 000", a, {reg_ack, ulpi_data_out}); end
          tick();
          ulpi_dir = 1'b0;
          tick(); #1;
          n_run++; if (ulpi_data_out !== 8'h00) begin n_fail++; $display("FAIL retry_idle_gap %0d: got %h want 00", a, ulpi_data_out); end
          tick();
        end
      end else begin
        tick(); #1;
        n_run++; if ({ulpi_stp, reg_ack, reg_err} !== 3'b110) begin n_fail++; $display("FAIL retry_success: got %b want 110", {ulpi_stp, reg_ack, reg_err}); end
        reg_req = 1'b0;
        tick();
        done = 1'b1;
      end
    end
  endtask

`ifdef ULPI_EXT_REG_EN
  task automatic test_ext_read();
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 8'h80; ulpi_nxt = 1'b1; ulpi_dir = 1'b0;
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'hEF) begin n_fail++; $display("FAIL ext_rd_cmd: got %h want ef", ulpi_data_out); end
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h80) begin n_fail++; $display("FAIL ext_rd_addr: got %h want 80", ulpi_data_out); end
    tick();
    ulpi_dir = 1'b1; ulpi_nxt = 1'b0;
    tick();
    ulpi_data_in = 8'h5A;
    tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; #1;
    n_run++; if ({reg_ack, reg_err, reg_rdata} !== {2'b10, 8'h5A}) begin n_fail++; $display("FAIL ext_rd_ack: got %h want 25a", {reg_ack, reg_err, reg_rdata}); end
    reg_req = 1'b0;
    tick();
  endtask

  task automatic test_ext_write();
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'hC1; reg_wdata = 8'h99; ulpi_nxt = 1'b1;
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'hAF) begin n_fail++; $display("FAIL ext_wr_cmd: got %h want af", ulpi_data_out); end
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'hC1) begin n_fail++; $display("FAIL ext_wr_addr: got %h want c1", ulpi_data_out); end
    tick(); #1;
    n_run++; if (ulpi_data_out !== 8'h99) begin n_fail++; $display("FAIL ext_wr_data: got %h want 99", ulpi_data_out); end
    tick(); #1;
    n_run++; if ({ulpi_stp, reg_ack, reg_err} !== 3'b110) begin n_fail++; $display("FAIL ext_wr_ack: got %b want 110", {ulpi_stp, reg_ack, reg_err}); end
    reg_req = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_ext();
    logic [7:0] addrs [2];
    addrs[0] = 8'h2F;
    addrs[1] = 8'h80;
    for (int i = 0; i < 2; i++) begin
      reg_req = 1'b1; reg_we = 1'b0; reg_addr = addrs[i]; ulpi_nxt = 1'b1; ulpi_dir = 1'b0;
      tick(); #1;
      n_run++; if ({reg_ack, reg_err, ulpi_data_out} !== {2'b11, 8'h00}) begin n_fail++; $display("FAIL noext_err %h: got %h want 300", addrs[i], {reg_ack, reg_err, ulpi_data_out}); end
      reg_req = 1'b0;
      tick(); #1;
      n_run++; if ({reg_ack, ulpi_data_out} !== 9'h0) begin n_fail++; $display("FAIL noext_quiet %h: got %h want 000", addrs[i], {reg_ack, ulpi_data_out}); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset();
    test_arbitration();
    test_imm_write();
    test_rxcmd();
    test_imm_read();
    test_retry(2);
    test_retry(3);
`ifdef ULPI_EXT_REG_EN
    test_ext_read();
    test_ext_write();
`else
    test_no_ext();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
